// File: rtl/id_seq.sv
// rtl/id_seq.sv - sequenced RK16 instruction-decode stage (optional ID_SEQ_SEXT_EN: sign-extended immediate)
module id_seq #(
    parameter  int ILEN   = 32,
    parameter  int XLEN   = 16,
    parameter  int IMM_W  = 16,
    parameter  int NSTAGE = 4,
    localparam int SW     = $clog2(NSTAGE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   stage,
    output logic            last,
    output logic [3:0]      opcode,
    output logic [3:0]      rd,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [XLEN-1:0] imm
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_STAGE = SW'(NSTAGE - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_stage;
    logic [SW-1:0]     w_stage_nxt;
    logic [ILEN-1:0]   r_ir;
    logic [ILEN-1:0]   w_ir_nxt;

    logic              w_at_last;
    logic              w_accept;
    logic [IMM_W-1:0]  w_imm_field;
    logic              w_unused_ir;

    // Ready is independent of in_valid so fetch may wait on it without a loop.
    assign w_at_last = (r_stage == LAST_STAGE);
    assign in_ready  = !flush && ((r_state == S_IDLE) || (w_at_last && out_ready));
    assign w_accept  = in_valid && in_ready;

    // State, stage counter and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    // Next state: flush beats accept, accept beats retire/advance; stall holds everything.
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_ir_nxt    = r_ir;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_stage_nxt = '0;
        end else if (w_accept) begin
            w_state_nxt = S_RUN;
            w_stage_nxt = '0;
            w_ir_nxt    = in_inst;
        end else if (r_state == S_RUN && out_ready) begin
            if (w_at_last) begin
                w_state_nxt = S_IDLE;
                w_stage_nxt = '0;
            end else begin
                w_stage_nxt = r_stage + SW'(1);
            end
        end
    end

    assign out_valid = (r_state == S_RUN);
    assign stage     = r_stage;
    assign last      = out_valid && w_at_last;

    // Decoded fields come straight from the held word, so they are stable for a whole RUN.
    assign opcode      = r_ir[3:0];
    assign rd          = r_ir[7:4];
    assign rs1         = r_ir[11:8];
    assign rs2         = r_ir[15:12];
    assign w_imm_field = r_ir[16 +: IMM_W];

`ifdef ID_SEQ_SEXT_EN
    assign imm = XLEN'($signed(w_imm_field));
`else
    assign imm = XLEN'(w_imm_field);
`endif

    // Upper instruction bits beyond the immediate are carried but not decoded.
    assign w_unused_ir = ^r_ir;

endmodule

// File: tb/tb_id_seq.sv
// tb/tb_id_seq.sv - self-checking bench for id_seq
module tb_id_seq;

    localparam int NST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;

    logic        in_ready, out_valid, last;
    logic [1:0]  stage;
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [15:0] imm;

    logic        in_ready12, out_valid12, last12;
    logic [1:0]  stage12;
    logic [3:0]  opcode12, rd12, rs112, rs212;
    logic [15:0] imm12;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: number of stages still to be presented (0 = nothing held)
    int          m_left;
    logic [31:0] m_ir;

    always #5 clk = ~clk;

    id_seq #(.ILEN(32), .XLEN(16), .IMM_W(16), .NSTAGE(NST)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .stage(stage),
        .last(last), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm)
    );

    id_seq #(.ILEN(32), .XLEN(16), .IMM_W(12), .NSTAGE(NST)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready12),
        .in_inst(in_inst), .out_valid(out_valid12), .out_ready(out_ready), .stage(stage12),
        .last(last12), .opcode(opcode12), .rd(rd12), .rs1(rs112), .rs2(rs212), .imm(imm12)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_imm(input logic [31:0] ir, input int w);
        longint f;
        f = (longint'(ir) >> 16) % (longint'(1) << w);
`ifdef ID_SEQ_SEXT_EN
        if (f >= (longint'(1) << (w - 1))) f = f + 65536 - (longint'(1) << w);
`endif
        return 16'(f);
    endfunction

    function automatic logic m_in_ready();
        return !flush && (m_left == 0 || (m_left == 1 && out_ready));
    endfunction

    task automatic model_check();
        int es;
        es = (m_left > 0) ? NST - m_left : 0;
        chk("out_valid", 32'(out_valid), 32'(m_left > 0));
        chk("stage", 32'(stage), 32'(es));
        chk("last", 32'(last), 32'(m_left == 1));
        chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
        chk("opcode", 32'(opcode), m_ir % 16);
        chk("rd", 32'(rd), (m_ir / 16) % 16);
        chk("rs1", 32'(rs1), (m_ir / 256) % 16);
        chk("rs2", 32'(rs2), (m_ir / 4096) % 16);
        chk("imm", 32'(imm), 32'(exp_imm(m_ir, 16)));
        chk("imm12", 32'(imm12), 32'(exp_imm(m_ir, 12)));
        chk("in_ready12", 32'(in_ready12), 32'(m_in_ready()));
        chk("stage12", 32'(stage12), 32'(es));
    endtask

    task automatic model_edge();
        logic rdy;
        rdy = m_in_ready();
        if (flush) m_left = 0;
        else if (in_valid && rdy) begin
            m_left = NST;
            m_ir   = in_inst;
        end else if (m_left > 0 && out_ready) m_left = m_left - 1;
    endtask

    // inputs are changed only just after a negedge; one call = one clock
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic f, input logic iv, input logic ordy, input logic [31:0] inst);
        flush = f; in_valid = iv; out_ready = ordy; in_inst = inst;
    endtask

    typedef struct {
        logic        fl, iv, ordy;
        logic [31:0] inst;
        logic        ev, el, er;
        logic [1:0]  es;
        logic [15:0] eimm;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h1234_1234, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 2'd0, 16'h1234};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 2'd1, 16'h1234};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 2'd2, 16'h1234};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 1'b1, 2'd3, 16'h1234};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 2'd0, 16'h1234};

        // reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        m_left = 0; m_ir = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        model_check();
        @(negedge clk);
        rst_n = 1'b1;

        // single instruction, table driven
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].inst);
            #1;
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ev));
            chk("tbl_stage", 32'(stage), 32'(tbl[i].es));
            chk("tbl_last", 32'(last), 32'(tbl[i].el));
            chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].er));
            chk("tbl_imm", 32'(imm), 32'(tbl[i].eimm));
            if (i == 1) begin
                chk("tbl_opcode", 32'(opcode), 32'd4);
                chk("tbl_rd", 32'(rd), 32'd3);
                chk("tbl_rs1", 32'(rs1), 32'd2);
                chk("tbl_rs2", 32'(rs2), 32'd1);
            end
            tick();
        end

        // back-to-back with in_valid held
        drive(1'b0, 1'b1, 1'b1, 32'h4567_4567);
        tick();
        in_inst = 32'hCDEF_CDEF;
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("b2b_last_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_stage", 32'(stage), 32'd0);
        chk("b2b_imm", 32'(imm), 32'hCDEF);
        for (int i = 0; i < 5; i++) tick();

        // stall at stage 1
        drive(1'b0, 1'b1, 1'b1, 32'hA5C3_7E19);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_stage", 32'(stage), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_rd", 32'(rd), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_rel_stage1", 32'(stage), 32'd1);
        tick();
        #1;
        chk("stall_rel_stage2", 32'(stage), 32'd2);
        tick();
        #1;
        chk("stall_rel_stage3", 32'(stage), 32'd3);
        tick();
        tick();

        // flush at stage 2 with in_valid high
        drive(1'b0, 1'b1, 1'b1, 32'h1111_2222);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h3333_4444);
        #1;
        chk("flush_stage", 32'(stage), 32'd2);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("flush_next_valid", 32'(out_valid), 32'd1);
        chk("flush_next_imm", 32'(imm), 32'h3333);
        for (int i = 0; i < 4; i++) tick();

        // immediate extension, 12-bit field on the second instance
        drive(1'b0, 1'b1, 1'b1, 32'h89AB_0000);
        tick();
        in_valid = 1'b0;
        #1;
`ifdef ID_SEQ_SEXT_EN
        chk("imm12_ext", 32'(imm12), 32'hF9AB);
`else
        chk("imm12_ext", 32'(imm12), 32'h09AB);
`endif
        chk("imm16_ext", 32'(imm), 32'h89AB);
        tick();

        // async reset in the middle of stage 2
        tick();
        #2;
        chk("pre_rst_stage", 32'(stage), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_stage", 32'(stage), 32'd0);
        chk("arst_imm", 32'(imm), 32'd0);
        m_left = 0; m_ir = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) != 0), $urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
